alu_cmd_driver: RTL
===================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter ALU_LAT, default 1, meaning: clock edges from ALU operand capture to a valid ALU result; legal range 1..7.
REQ-002 Parameter CNT_W, default 16, meaning: width of the statistics counters.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  upstream command present.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_op  in  2  operation: 00 MUL, 01 DIV, 10 ADD, 11 SUB.
REQ-008 cmd_a, cmd_b  in  8 each  operands.
REQ-009 cmd_tag  in  4  opaque identifier, returned with the result.
REQ-010 alu_sel  out  2  opcode driven to the ALU.
REQ-011 alu_a, alu_b  out  8 each  operands driven to the ALU.
REQ-012 alu_y  in  8  ALU registered result.
REQ-013 rsp_valid  out  1  result present.
REQ-014 rsp_ready  in  1  downstream accepts the result.
REQ-015 rsp_y  out  8  result.
REQ-016 rsp_op  out  2  opcode of the result.
REQ-017 rsp_tag  out  4  tag of the result.
REQ-018 rsp_divz  out  1  set when op was DIV with b==0.
REQ-019 done_cnt, divz_cnt  out  CNT_W each  completed-response count and divide-by-zero count.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; an accept is cmd_valid & cmd_ready at a rising edge.
REQ-022 On accept, the block SHALL register op/a/b/tag, drive them on alu_sel/alu_a/alu_b from the next cycle, load lat_cnt=ALU_LAT and move IDLE->WAIT.
REQ-023 alu_sel, alu_a and alu_b SHALL stay stable from accept until the next accept; they are never changed in WAIT or RESP.
REQ-024 WAIT SHALL last exactly ALU_LAT+1 cycles; on its final edge, alu_y SHALL be captured into rsp_y, the block SHALL move WAIT->RESP, and rsp_valid SHALL rise.
REQ-025 With ALU_LAT=1, rsp_valid SHALL therefore first be high 2 cycles after the accept edge.
REQ-026 rsp_divz SHALL be computed from the registered op==DIV and b==0, independent of alu_y.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_y/op/tag/divz SHALL be held stable until rsp_ready=1 at an edge; that edge SHALL move RESP->IDLE.
REQ-028 rsp_valid SHALL NOT depend combinationally on rsp_ready, and cmd_ready SHALL NOT depend combinationally on cmd_valid.
REQ-029 Throughput: at most one command per ALU_LAT+3 cycles; no overlapping commands.
REQ-030 done_cnt SHALL increment on every response handshake; divz_cnt SHALL increment on a handshake with rsp_divz=1.
REQ-031 Both counters SHALL wrap modulo 2^CNT_W.
REQ-032 cmd_valid in WAIT or RESP SHALL be ignored; the command is not lost, because cmd_ready=0.

Reset
REQ-033 Asserting rst SHALL immediately force IDLE and clear lat_cnt, rsp_valid, rsp_y, rsp_op, rsp_tag, rsp_divz, alu_sel, alu_a, alu_b, done_cnt and divz_cnt to 0.
REQ-034 A reset in WAIT or RESP SHALL drop the in-flight command without a response; counters are not incremented.
REQ-035 cmd_ready SHALL be 0 while rst=1 and 1 from the first cycle after release.

Structure
REQ-036 A shared package alu_pkg SHALL hold the opcode enum (OP_MUL=2'b00, OP_DIV=2'b01, OP_ADD=2'b10, OP_SUB=2'b11), the FSM state enum and the 8-bit data width constant.
REQ-037 No sub-module SHALL be used; the latency counter and statistics counters are implemented inline.

Verification
REQ-038 ADD a=200, b=100, tag=3 -> rsp_y=44, rsp_tag=3, rsp_divz=0, rsp_valid high 2 cycles after accept.
REQ-039 MUL 20*13 -> rsp_y=4; SUB 5-9 -> rsp_y=252; DIV 200/7 -> rsp_y=28.
REQ-040 DIV a=7, b=0 -> rsp_y=0, rsp_divz=1, divz_cnt increments 0->1 at the handshake.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, alu_* unchanged, done_cnt unchanged until the handshake.
REQ-042 Assert rst one cycle after accept -> all outputs 0 asynchronously, no response, cmd_ready=1 the cycle after release.
REQ-043 Issue 65537 back-to-back commands with CNT_W=16 -> done_cnt=1 (wrap).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, command-driver FSM states, data width.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_DIV = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Drives one command at a time into a fixed-latency ALU and returns the
// result with its tag on a valid/ready response port; keeps simple stats.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,   // 1..7: edges from operand capture to valid alu_y
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [3:0]        cmd_tag,
    output logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [1:0]        rsp_op,
    output logic [3:0]        rsp_tag,
    output logic              rsp_divz,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  divz_cnt
);

    state_e     state, state_nxt;
    logic [2:0] lat_cnt;
    logic [3:0] tag_q;
    logic       accept, capture, rsp_hs;

    // Ready only in IDLE and never while reset is held.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (lat_cnt == 3'd0) begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_hs    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers (held until the next accept) and latency countdown;
    // WAIT spans ALU_LAT+1 edges because the countdown runs to zero first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            tag_q   <= '0;
            lat_cnt <= '0;
        end else if (accept) begin
            alu_sel <= cmd_op;
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            tag_q   <= cmd_tag;
            lat_cnt <= 3'(ALU_LAT);
        end else if (state == WAIT && lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Response capture; divide-by-zero comes from the held operands, not alu_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y    <= '0;
            rsp_op   <= '0;
            rsp_tag  <= '0;
            rsp_divz <= 1'b0;
        end else if (capture) begin
            rsp_y    <= alu_y;
            rsp_op   <= alu_sel;
            rsp_tag  <= tag_q;
            rsp_divz <= (alu_sel == 2'(OP_DIV)) && (alu_b == '0);
        end
    end

    // Statistics counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
            divz_cnt <= '0;
        end else if (rsp_hs) begin
            done_cnt <= done_cnt + 1'b1;
            if (rsp_divz) divz_cnt <= divz_cnt + 1'b1;
        end
    end

endmodule
